pcie_tlp_framer: RTL and testbench
==================================

// Module: pcie_tlp_framer
// PURPOSE
//  Upstream stage of PKT_Detector. Accepts one parallel TLP (up to 20 bytes) over a valid/ready handshake.
//  Serializes it one byte per clock onto an 8-bit symbol stream plus a K-flag, framed STP ... END.
//  Output drives PKT_Detector's data_in/dataK directly. Also used as the reference source for the detector bench.
// PARAMETERS
//  DATA_WIDTH     8    symbol width of data_out
//  PKT_CNT_WIDTH  4    width of frame_cnt (wraps)
//  OUT_PKT_WIDTH  160  width of tlp_data; max TLP = OUT_PKT_WIDTH/8 = 20 bytes
//  MIN_LEN        12   smallest legal TLP length in bytes (3DW header)
//  IDLE_GAP       2    idle symbols forced after END/EDB before tlp_ready returns
// PORTS
//  clk        in   1              clock, rising edge
//  reset      in   1              asynchronous, active-high
//  tlp_valid  in   1              tlp_data/tlp_len valid
//  tlp_ready  out  1              framer can accept a TLP
//  tlp_data   in   OUT_PKT_WIDTH  TLP bytes; byte 0 = [OUT_PKT_WIDTH-1 -: 8], sent first
//  tlp_len    in   5              TLP length in bytes
//  tlp_abort  in   1              nullify the frame in flight
//  data_out   out  DATA_WIDTH     symbol to PKT_Detector data_in
//  dataK_out  out  1              1 = data_out is a K symbol
//  frame_cnt  out  PKT_CNT_WIDTH  frames closed with END (not EDB, not rejected)
//  len_err    out  1              1-cycle pulse: accepted TLP rejected for illegal length
// BEHAVIOUR
//  Reset (async): state IDLE; data_out=8'h00, dataK_out=0, tlp_ready=1, frame_cnt=0, len_err=0, seq=0.
//  Reset mid-frame aborts it immediately; no END/EDB emitted. Stream restarts in IDLE after deassert.
//  All outputs are registered. Idle symbol = 8'h00 with dataK_out=0.
//  Handshake: transfer when tlp_valid&&tlp_ready. tlp_ready=1 only in IDLE and falls the cycle after a transfer.
//  Legal length: MIN_LEN <= tlp_len <= OUT_PKT_WIDTH/8.
//   Illegal length: the transfer is still consumed. len_err=1 for 1 cycle; state stays IDLE; nothing is sent.
//  FSM: IDLE -> STP -> [SEQ_HI -> SEQ_LO] -> BODY -> END|EDB -> GAP -> IDLE.
//   STP:   data_out=8'hFB, K=1, first cycle after transfer (latency 1).
//   BODY:  tlp_len cycles; byte n = tlp_data byte n; K=0; a down-counter counts remaining bytes.
//   END:   8'hFD, K=1; frame_cnt increments (wraps modulo 2^PKT_CNT_WIDTH).
//   EDB:   8'hFE, K=1 replaces END if tlp_abort was sampled high in any STP/SEQ/BODY cycle.
//          The abort is latched; BODY still completes its full byte count. frame_cnt is unchanged.
//   GAP:   IDLE_GAP idle symbols. tlp_ready=0 throughout GAP, then returns to 1 in IDLE.
//  tlp_abort in IDLE/GAP/END: ignored.
//  Abort on the last BODY byte: that byte is sent, then EDB.
//  Frame length on the wire = 1 + tlp_len + 1 symbols (+2 with SEQ).
// CONFIGURATION
//  TLP_FRAMER_SEQ_EN defined:
//   - SEQ_HI/SEQ_LO are inserted after STP: {4'h0, seq[11:8]} then seq[7:0], K=0.
//   - The 12-bit seq increments after each END only (not on EDB) and wraps 4095 -> 0.
//  TLP_FRAMER_SEQ_EN undefined: the SEQ states, seq counter and logic are absent; STP goes directly to BODY.
// STRUCTURE
//  Package pcie_sym_pkg holds:
//   - constants K_STP=8'hFB, K_END=8'hFD, K_EDB=8'hFE, SYM_IDLE=8'h00
//   - typedef enum framer_state_t {IDLE, STP, SEQ_HI, SEQ_LO, BODY, END, EDB, GAP}
//  PKT_Detector imports the same package.
//  Sub-module tlp_byte_shifter is a parallel-load, MSB-first byte shift register:
//   - load on transfer, shift on each BODY cycle, exposes the current byte.
//  The FSM, counters and output registers live in pcie_tlp_framer.
// TESTING (TLP_FRAMER_SEQ_EN undefined unless stated)
//  1. tlp_len=12, bytes 00..0B -> 1 cycle after transfer:
//     FB/K1, 00..0B/K0, FD/K1, 2 idles; frame_cnt 0->1; tlp_ready=1 again 16 cycles after transfer.
//  2. tlp_abort pulsed on 5th BODY byte of a 16-byte TLP -> all 16 bytes sent, then FE/K1; frame_cnt unchanged.
//  3. tlp_len=11 and then tlp_len=21 -> each consumed in 1 cycle, len_err pulse each time; data_out stays 00/K0.
//  4. 16 back-to-back legal TLPs with tlp_valid held high -> frame_cnt wraps 15->0;
//     every frame is separated by exactly 2 idles.
//  5. reset asserted on 3rd BODY byte -> same cycle data_out=00/K0 and tlp_ready=1; no FD/FE emitted.
//  6. SEQ_EN defined, 2 frames with EDB between -> seq bytes 00 00, then 00 01 (EDB frame), then 00 01.
//  Feed the output into PKT_Detector. Each END frame must raise exactly one detector packet; EDB frames must raise none.

Source files
------------

// File: rtl/pcie_sym_pkg.sv
// Shared PCIe symbol constants and framer state encoding.
// Imported by the TLP framer and by PKT_Detector.
package pcie_sym_pkg;

  localparam logic [7:0] K_STP    = 8'hFB;
  localparam logic [7:0] K_END    = 8'hFD;
  localparam logic [7:0] K_EDB    = 8'hFE;
  localparam logic [7:0] SYM_IDLE = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    STP,
    SEQ_HI,
    SEQ_LO,
    BODY,
    END,
    EDB,
    GAP
  } framer_state_t;

endpackage

// File: rtl/tlp_byte_shifter.sv
// Parallel-load, MSB-first byte shift register for TLP payloads.
// Byte 0 sits in the top byte after load; each shift exposes the next.
module tlp_byte_shifter
  import pcie_sym_pkg::*;
#(
  parameter int W = 160
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [7:0]   cur_byte
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  // load wins over shift; shifting fills with idle bytes
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = {data_q[W-9:0], SYM_IDLE};
    end
  end

  // payload register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign cur_byte = data_q[W-1 -: 8];

endmodule

// File: rtl/pcie_tlp_framer.sv
// Serializes one parallel TLP into an STP..END/EDB framed byte stream.
// Optional TLP_FRAMER_SEQ_EN inserts a 12-bit sequence number after STP.
module pcie_tlp_framer
  import pcie_sym_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int PKT_CNT_WIDTH = 4,
  parameter int OUT_PKT_WIDTH = 160,
  parameter int MIN_LEN       = 12,
  parameter int IDLE_GAP      = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tlp_valid,
  output logic                     tlp_ready,
  input  logic [OUT_PKT_WIDTH-1:0] tlp_data,
  input  logic [4:0]               tlp_len,
  input  logic                     tlp_abort,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     dataK_out,
  output logic [PKT_CNT_WIDTH-1:0] frame_cnt,
  output logic                     len_err
);

  localparam logic [4:0] MIN_L = 5'(MIN_LEN);
  localparam logic [4:0] MAX_L = 5'(OUT_PKT_WIDTH / 8);
  // the IDLE cycle that re-raises tlp_ready is the last gap symbol
  localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP - 2);

  framer_state_t state_q, state_d;
  logic [4:0]  rem_q, rem_d;
  logic [3:0]  gap_q, gap_d;
  logic        abort_q, abort_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic        dataK_q, dataK_d;
  logic        ready_q, ready_d;
  logic [PKT_CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic        len_err_q, len_err_d;
`ifdef TLP_FRAMER_SEQ_EN
  logic [11:0] seq_q, seq_d;
`endif

  logic       xfer;
  logic       legal;
  logic       load;
  logic       shift;
  logic [7:0] cur_byte;

  assign xfer  = tlp_valid & ready_q;
  assign legal = (tlp_len >= MIN_L) && (tlp_len <= MAX_L);

  tlp_byte_shifter #(
    .W(OUT_PKT_WIDTH)
  ) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .din      (tlp_data),
    .cur_byte (cur_byte)
  );

  // next state, byte/gap counters and abort latch
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    gap_d     = gap_q;
    abort_d   = abort_q;
    len_err_d = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (legal) begin
            state_d = STP;
            load    = 1'b1;
            rem_d   = tlp_len;
            abort_d = 1'b0;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      STP: begin
        abort_d = abort_q | tlp_abort;
`ifdef TLP_FRAMER_SEQ_EN
        state_d = SEQ_HI;
`else
        state_d = BODY;
`endif
      end
      SEQ_HI: begin
        abort_d = abort_q | tlp_abort;
        state_d = SEQ_LO;
      end
      SEQ_LO: begin
        abort_d = abort_q | tlp_abort;
        state_d = BODY;
      end
      BODY: begin
        abort_d = abort_q | tlp_abort;
        if (rem_q == 5'd0) begin
          state_d = abort_d ? EDB : END;
        end
      end
      END, EDB: begin
        state_d = GAP;
        gap_d   = GAP_LOAD;
      end
      GAP: begin
        if (gap_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
    endcase
    if (state_d == BODY) begin
      rem_d = rem_q - 5'd1;
    end
  end

  // registered symbol, ready and counters for the upcoming state
  always_comb begin
    data_out_d  = DATA_WIDTH'(SYM_IDLE);
    dataK_d     = 1'b0;
    frame_cnt_d = frame_cnt_q;
    shift       = 1'b0;
    ready_d     = (state_d == IDLE);
`ifdef TLP_FRAMER_SEQ_EN
    seq_d       = seq_q;
`endif
    unique case (state_d)
      STP: begin
        data_out_d = DATA_WIDTH'(K_STP);
        dataK_d    = 1'b1;
      end
`ifdef TLP_FRAMER_SEQ_EN
      SEQ_HI: data_out_d = DATA_WIDTH'({4'h0, seq_q[11:8]});
      SEQ_LO: data_out_d = DATA_WIDTH'(seq_q[7:0]);
`endif
      BODY: begin
        data_out_d = DATA_WIDTH'(cur_byte);
        shift      = 1'b1;
      end
      END: begin
        data_out_d  = DATA_WIDTH'(K_END);
        dataK_d     = 1'b1;
        frame_cnt_d = frame_cnt_q + PKT_CNT_WIDTH'(1);
`ifdef TLP_FRAMER_SEQ_EN
        seq_d       = seq_q + 12'd1;
`endif
      end
      EDB: begin
        data_out_d = DATA_WIDTH'(K_EDB);
        dataK_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      gap_q       <= '0;
      abort_q     <= 1'b0;
      data_out_q  <= '0;
      dataK_q     <= 1'b0;
      ready_q     <= 1'b1;
      frame_cnt_q <= '0;
      len_err_q   <= 1'b0;
`ifdef TLP_FRAMER_SEQ_EN
      seq_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      abort_q     <= abort_d;
      data_out_q  <= data_out_d;
      dataK_q     <= dataK_d;
      ready_q     <= ready_d;
      frame_cnt_q <= frame_cnt_d;
      len_err_q   <= len_err_d;
`ifdef TLP_FRAMER_SEQ_EN
      seq_q       <= seq_d;
`endif
    end
  end

  assign tlp_ready = ready_q;
  assign data_out  = data_out_q;
  assign dataK_out = dataK_q;
  assign frame_cnt = frame_cnt_q;
  assign len_err   = len_err_q;

endmodule

// File: tb/tb_pcie_tlp_framer.sv
// Randomized bench for pcie_tlp_framer with a symbol-list reference model.
// Honours TLP_FRAMER_SEQ_EN when defined at compile time.
module tb_pcie_tlp_framer;
  import pcie_sym_pkg::*;

`ifdef TLP_FRAMER_SEQ_EN
  localparam int SQ = 2;
`else
  localparam int SQ = 0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         tlp_valid;
  logic         tlp_ready;
  logic [159:0] tlp_data;
  logic [4:0]   tlp_len;
  logic         tlp_abort;
  logic [7:0]   data_out;
  logic         dataK_out;
  logic [3:0]   frame_cnt;
  logic         len_err;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  int exp_seq = 0;

  always #5 clk = ~clk;

  pcie_tlp_framer dut (
    .clk       (clk),
    .reset     (reset),
    .tlp_valid (tlp_valid),
    .tlp_ready (tlp_ready),
    .tlp_data  (tlp_data),
    .tlp_len   (tlp_len),
    .tlp_abort (tlp_abort),
    .data_out  (data_out),
    .dataK_out (dataK_out),
    .frame_cnt (frame_cnt),
    .len_err   (len_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Caller is positioned just after a falling edge.
  // ab_c: cycle after transfer (1 = STP on wire) in which abort is high.
  task automatic send(input int len, input int ab_c, input bit keep,
                      input bit dir);
    logic [7:0] b [20];
    logic [8:0] exp_sym [$];
    bit legal;
    bit aborted;
    int n;
    for (int i = 0; i < 20; i++) begin
      b[i] = dir ? 8'(i) : 8'($urandom);
      tlp_data[159-8*i -: 8] = b[i];
    end
    chk("ready_pre", tlp_ready, 1);
    tlp_valid = 1'b1;
    tlp_len   = 5'(len);
    legal = (len >= 12) && (len <= 20);
    if (!legal) begin
      @(negedge clk);
      tlp_valid = 1'b0;
      chk("len_err_on", len_err, 1);
      chk("ready_ill", tlp_ready, 1);
      chk("idle_ill", {dataK_out, data_out}, 9'h000);
      @(negedge clk);
      chk("len_err_off", len_err, 0);
      chk("idle_ill2", {dataK_out, data_out}, 9'h000);
      return;
    end
    aborted = (ab_c >= 1) && (ab_c <= len + 1 + SQ);
    exp_sym.push_back({1'b1, K_STP});
    if (SQ != 0) begin
      exp_sym.push_back({1'b0, 4'h0, 4'((exp_seq >> 8) & 15)});
      exp_sym.push_back({1'b0, 8'(exp_seq & 255)});
    end
    for (int i = 0; i < len; i++) exp_sym.push_back({1'b0, b[i]});
    exp_sym.push_back(aborted ? {1'b1, K_EDB} : {1'b1, K_END});
    exp_sym.push_back(9'h000);
    exp_sym.push_back(9'h000);
    if (!aborted) begin
      exp_cnt = (exp_cnt + 1) % 16;
      exp_seq = (exp_seq + 1) % 4096;
    end
    n = len + 4 + SQ;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1 && !keep) tlp_valid = 1'b0;
      tlp_abort = (c == ab_c);
      chk("sym", {dataK_out, data_out}, exp_sym[c-1]);
      chk("ready", tlp_ready, (c == n) ? 1 : 0);
      chk("len_err_0", len_err, 0);
    end
    tlp_abort = 1'b0;
    chk("frame_cnt", frame_cnt, exp_cnt);
  endtask

  task automatic reset_mid_frame();
    logic [7:0] b [20];
    for (int i = 0; i < 20; i++) begin
      b[i] = 8'($urandom);
      tlp_data[159-8*i -: 8] = b[i];
    end
    tlp_valid = 1'b1;
    tlp_len   = 5'd16;
    for (int c = 1; c <= SQ + 4; c++) begin
      @(negedge clk);
      tlp_valid = 1'b0;
    end
    chk("body3", {dataK_out, data_out}, {1'b0, b[2]});
    reset = 1'b1;
    #1;
    chk("rst_sym", {dataK_out, data_out}, 9'h000);
    chk("rst_ready", tlp_ready, 1);
    chk("rst_cnt", frame_cnt, 0);
    exp_cnt = 0;
    exp_seq = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("post_rst_idle", {dataK_out, data_out}, 9'h000);
    end
  endtask

  initial begin
    int len;
    int ab;
    reset     = 1'b1;
    tlp_valid = 1'b0;
    tlp_data  = '0;
    tlp_len   = '0;
    tlp_abort = 1'b0;
    #1;
    chk("rst_data", {dataK_out, data_out}, 9'h000);
    chk("rst_ready", tlp_ready, 1);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_len_err", len_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    send(12, -1, 1'b0, 1'b1);
    send(16, SQ + 6, 1'b0, 1'b0);
    send(16, 16 + SQ + 1, 1'b0, 1'b0);
    send(12, 12 + SQ + 2, 1'b0, 1'b0);
    send(11, -1, 1'b0, 1'b0);
    send(21, -1, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      send($urandom_range(12, 20), -1, k < 15, 1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      len = $urandom_range(8, 23);
      ab = ($urandom_range(0, 2) == 0) ?
           $urandom_range(1, len + 4 + SQ) : -1;
      send(len, ab, 1'($urandom_range(0, 1)), 1'b0);
    end

    reset_mid_frame();
    send(20, -1, 1'b0, 1'b0);
    send(13, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
